button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Upstream stage of the player-action FSM. Takes the raw, asynchronous, bouncing push-button
//  inputs and produces clean, synchronised, debounced levels. The action FSM consumes them
//  directly on its `buttons[2:0]` input.
//  Also emits one-cycle press/release pulses per button for counters and diagnostic logic.
// PARAMETERS
//  N_BUTTONS        3   number of independent button channels (action FSM uses 3)
//  SYNC_STAGES      2   flops in metastability synchroniser per channel; legal >= 2
//  DEBOUNCE_CYCLES  4   consecutive synchronised samples needed to accept a level change; legal >= 2
// PORTS
//  clk          in   1          rising-edge clock, shared with the action FSM
//  reset        in   1          synchronous, active-high; one clock, clk
//  raw_buttons  in   N_BUTTONS  asynchronous bouncing inputs; bit2=jump, bit1=run, bit0=aux
//  buttons      out  N_BUTTONS  debounced level; connects to the action FSM `buttons`
//  pressed      out  N_BUTTONS  1-cycle pulse in the first cycle buttons[i] is high
//  released     out  N_BUTTONS  1-cycle pulse in the first cycle buttons[i] is low after being high
// BEHAVIOUR
//  - Reset (sync, active-high, checked at posedge clk):
//    - all synchroniser flops <= 0
//    - every channel state <= DB_LO, count <= 0
//    - buttons/pressed/released = 0 in the cycle after the reset edge
//    - reset mid-bounce discards any partial count; reset wins over any input activity
//  - Channels are fully independent. Simultaneous edges on several bits are each handled on
//    their own with no priority, e.g. 3'b101 rising together yields buttons=3'b101 on the same edge.
//  - Synchroniser: raw_buttons[i] shifts through SYNC_STAGES flops; the last stage is sync[i].
//  - Per-channel FSM (state, count; count width $clog2(DEBOUNCE_CYCLES)):
//    - DB_LO:     sync=1 -> DB_CHK_HI, count<=1;  else stay, count<=0
//    - DB_CHK_HI: sync=0 -> DB_LO, count<=0;  count==DEBOUNCE_CYCLES-1 -> DB_HI, count<=0;
//                 else count<=count+1
//    - DB_HI:     sync=0 -> DB_CHK_LO, count<=1;  else stay, count<=0
//    - DB_CHK_LO: sync=1 -> DB_HI, count<=0;  count==DEBOUNCE_CYCLES-1 -> DB_LO, count<=0;
//                 else count<=count+1
//    - default/illegal encoding -> DB_LO
//  - buttons[i] = (state==DB_HI || state==DB_CHK_LO). Level holds during the low-check window.
//  - Level change accepted only after DEBOUNCE_CYCLES consecutive identical sync samples.
//    Any opposite sample returns to the current stable state with count cleared.
//    count never wraps.
//  - Latency: a clean raw edge is reflected on buttons at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th
//    rising edge that samples the new raw level. Defaults: 6th edge.
//  - buttons_d = buttons registered one cycle (reset 0).
//    pressed = buttons & ~buttons_d; released = ~buttons & buttons_d.
//    Each pulse lasts exactly one cycle per accepted change.
//  - Pulses shorter than DEBOUNCE_CYCLES cycles at sync never change buttons or pulse outputs.
// STRUCTURE
//  - Package button_pkg:
//    - typedef enum logic [1:0] {DB_LO, DB_CHK_HI, DB_HI, DB_CHK_LO} db_state_t
//    - localparams BTN_JUMP=2, BTN_RUN=1, BTN_AUX=0
//    - default N_BUTTONS=3
//  - Sub-module debounce_channel: synchroniser + FSM + counter + edge pulses for one bit.
//  - Top instantiates N_BUTTONS copies in a generate loop; no shared state between channels.
// TESTING (defaults; 10 ns clock)
//  1 reset=1 for 1 cycle with raw=3'b111 -> buttons=pressed=released=0 the next cycle;
//    channels then debounce the held 1s normally.
//  2 raw[2] 0->1 held 10 cycles -> buttons[2] rises on the 6th sampling edge;
//    pressed[2]=1 for exactly that cycle.
//  3 raw[1] high for 3 cycles then low (glitch) -> buttons[1] stays 0; no pulse.
//  4 raw[2] bounce 1,0,1,1,1,1 then steady -> acceptance restarts after the 0;
//    buttons[2] rises 4 edges after sync shows steady 1.
//  5 buttons=3'b100 stable, then raw=3'b101 -> buttons=3'b101 (jump+aux) after 6 edges;
//    pressed=3'b001 for one cycle.
//  6 reset asserted while channel 0 is in DB_CHK_HI (count=2) -> after reset, count=0 and
//    state DB_LO; raw must again be stable for 6 edges.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning path.
// Pure declarations; no latency or flow control of its own.
// Channel indices match the action FSM's buttons[2:0] bit assignment.
package button_pkg;

    typedef enum logic [1:0] {
        DB_LO     = 2'd0,
        DB_CHK_HI = 2'd1,
        DB_HI     = 2'd2,
        DB_CHK_LO = 2'd3
    } db_state_t;

    localparam int BTN_JUMP      = 2;
    localparam int BTN_RUN       = 1;
    localparam int BTN_AUX       = 0;
    localparam int BTN_N_BUTTONS = 3;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce FSM with run-length counter, edge pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES rising edges from a clean raw edge to level.
// No backpressure: free-running, samples every cycle.
module debounce_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    db_state_t              state, state_nxt;
    logic [CW-1:0]          count, count_nxt;
    logic                   level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state   <= DB_LO;
            count   <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state   <= state_nxt;
            count   <= count_nxt;
            level_d <= level;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Any opposite sample drops back to the current stable state; count never wraps
    // because reaching CNT_LAST always leaves the check state.
    always_comb begin
        state_nxt = DB_LO;
        count_nxt = '0;
        case (state)
            DB_LO: begin
                if (sync) begin
                    state_nxt = DB_CHK_HI;
                    count_nxt = CW'(1);
                end else begin
                    state_nxt = DB_LO;
                end
            end
            DB_CHK_HI: begin
                if (!sync) begin
                    state_nxt = DB_LO;
                end else if (count == CNT_LAST) begin
                    state_nxt = DB_HI;
                end else begin
                    state_nxt = DB_CHK_HI;
                    count_nxt = count + CW'(1);
                end
            end
            DB_HI: begin
                if (!sync) begin
                    state_nxt = DB_CHK_LO;
                    count_nxt = CW'(1);
                end else begin
                    state_nxt = DB_HI;
                end
            end
            DB_CHK_LO: begin
                if (sync) begin
                    state_nxt = DB_HI;
                end else if (count == CNT_LAST) begin
                    state_nxt = DB_LO;
                end else begin
                    state_nxt = DB_CHK_LO;
                    count_nxt = count + CW'(1);
                end
            end
            default: begin
                state_nxt = DB_LO;
                count_nxt = '0;
            end
        endcase
    end

    // Level stays high while a release is still being qualified.
    assign level    = (state == DB_HI) || (state == DB_CHK_LO);
    assign pressed  = level & ~level_d;
    assign released = ~level & level_d;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw bouncing push-buttons into clean levels plus press/release pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges (6 at defaults) from raw edge to buttons.
// No backpressure: outputs are levels/pulses consumed directly by the action FSM.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = BTN_N_BUTTONS,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] raw_buttons,
    output logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] released
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .raw     (raw_buttons[i]),
            .level   (buttons[i]),
            .pressed (pressed[i]),
            .released(released[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at default parameters.
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic [2:0] raw_buttons;
    logic [2:0] buttons;
    logic [2:0] pressed;
    logic [2:0] released;

    int total = 0;
    int bad   = 0;

    button_conditioner dut (
        .clk        (clk),
        .reset      (reset),
        .raw_buttons(raw_buttons),
        .buttons    (buttons),
        .pressed    (pressed),
        .released   (released)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw_buttons = 3'b111;
        tick(1);
        reset = 1'b0;
        total++;
        if (buttons !== 3'b000) begin
            bad++; $display("FAIL reset_buttons got=%b exp=%b", buttons, 3'b000);
        end
        total++;
        if (pressed !== 3'b000) begin
            bad++; $display("FAIL reset_pressed got=%b exp=%b", pressed, 3'b000);
        end
        total++;
        if (released !== 3'b000) begin
            bad++; $display("FAIL reset_released got=%b exp=%b", released, 3'b000);
        end
        tick(5);
        total++;
        if (buttons !== 3'b000) begin
            bad++; $display("FAIL reset_early got=%b exp=%b", buttons, 3'b000);
        end
        tick(1);
        total++;
        if (buttons !== 3'b111 || pressed !== 3'b111) begin
            bad++; $display("FAIL reset_accept got=%b/%b exp=111/111", buttons, pressed);
        end
        raw_buttons = 3'b000;
        tick(5);
        total++;
        if (buttons !== 3'b111) begin
            bad++; $display("FAIL release_hold got=%b exp=%b", buttons, 3'b111);
        end
        tick(1);
        total++;
        if (buttons !== 3'b000 || released !== 3'b111) begin
            bad++; $display("FAIL release_all got=%b/%b exp=000/111", buttons, released);
        end
        tick(1);
        total++;
        if (released !== 3'b000) begin
            bad++; $display("FAIL release_pulse_len got=%b exp=%b", released, 3'b000);
        end
    endtask

    task automatic test_clean_press();
        raw_buttons = 3'b100;
        tick(5);
        total++;
        if (buttons !== 3'b000) begin
            bad++; $display("FAIL press_edge5 got=%b exp=%b", buttons, 3'b000);
        end
        tick(1);
        total++;
        if (buttons !== 3'b100 || pressed !== 3'b100) begin
            bad++; $display("FAIL press_edge6 got=%b/%b exp=100/100", buttons, pressed);
        end
        tick(1);
        total++;
        if (buttons !== 3'b100 || pressed !== 3'b000) begin
            bad++; $display("FAIL press_edge7 got=%b/%b exp=100/000", buttons, pressed);
        end
        tick(3);
    endtask

    task automatic test_simultaneous();
        raw_buttons = 3'b101;
        tick(5);
        total++;
        if (buttons !== 3'b100) begin
            bad++; $display("FAIL aux_edge5 got=%b exp=%b", buttons, 3'b100);
        end
        tick(1);
        total++;
        if (buttons !== 3'b101 || pressed !== 3'b001 || released !== 3'b000) begin
            bad++; $display("FAIL aux_edge6 got=%b/%b/%b exp=101/001/000", buttons, pressed, released);
        end
        raw_buttons = 3'b000;
        tick(6);
        total++;
        if (buttons !== 3'b000 || released !== 3'b101) begin
            bad++; $display("FAIL aux_release got=%b/%b exp=000/101", buttons, released);
        end
        tick(2);
    endtask

    task automatic test_glitch();
        logic [2:0] seen_btn;
        logic [2:0] seen_pls;
        seen_btn = 3'b000;
        seen_pls = 3'b000;
        raw_buttons = 3'b010;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) raw_buttons = 3'b000;
            tick(1);
            seen_btn = seen_btn | buttons;
            seen_pls = seen_pls | pressed | released;
        end
        total++;
        if (seen_btn !== 3'b000) begin
            bad++; $display("FAIL glitch_level got=%b exp=%b", seen_btn, 3'b000);
        end
        total++;
        if (seen_pls !== 3'b000) begin
            bad++; $display("FAIL glitch_pulse got=%b exp=%b", seen_pls, 3'b000);
        end
    endtask

    // Exactly DEBOUNCE_CYCLES high samples is the shortest accepted press.
    task automatic test_min_pulse();
        raw_buttons = 3'b010;
        tick(4);
        raw_buttons = 3'b000;
        tick(2);
        total++;
        if (buttons !== 3'b010 || pressed !== 3'b010) begin
            bad++; $display("FAIL min_accept got=%b/%b exp=010/010", buttons, pressed);
        end
        tick(3);
        total++;
        if (buttons !== 3'b010) begin
            bad++; $display("FAIL min_hold got=%b exp=%b", buttons, 3'b010);
        end
        tick(1);
        total++;
        if (buttons !== 3'b000 || released !== 3'b010) begin
            bad++; $display("FAIL min_release got=%b/%b exp=000/010", buttons, released);
        end
        tick(2);
    endtask

    task automatic test_bounce();
        raw_buttons = 3'b100;
        tick(1);
        raw_buttons = 3'b000;
        tick(1);
        raw_buttons = 3'b100;
        tick(5);
        total++;
        if (buttons !== 3'b000) begin
            bad++; $display("FAIL bounce_early got=%b exp=%b", buttons, 3'b000);
        end
        tick(1);
        total++;
        if (buttons !== 3'b100 || pressed !== 3'b100) begin
            bad++; $display("FAIL bounce_accept got=%b/%b exp=100/100", buttons, pressed);
        end
        raw_buttons = 3'b000;
        tick(6);
        total++;
        if (buttons !== 3'b000) begin
            bad++; $display("FAIL bounce_clear got=%b exp=%b", buttons, 3'b000);
        end
        tick(2);
    endtask

    // Reset after two qualifying samples on channel 0 must restart the full window.
    task automatic test_reset_mid_bounce();
        raw_buttons = 3'b001;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        total++;
        if (buttons !== 3'b000 || pressed !== 3'b000) begin
            bad++; $display("FAIL midrst_after got=%b/%b exp=000/000", buttons, pressed);
        end
        tick(5);
        total++;
        if (buttons !== 3'b000) begin
            bad++; $display("FAIL midrst_early got=%b exp=%b", buttons, 3'b000);
        end
        tick(1);
        total++;
        if (buttons !== 3'b001 || pressed !== 3'b001) begin
            bad++; $display("FAIL midrst_accept got=%b/%b exp=001/001", buttons, pressed);
        end
    endtask

    initial begin
        reset = 1'b0;
        raw_buttons = 3'b000;
        #2;
        test_reset();
        test_clean_press();
        test_simultaneous();
        test_glitch();
        test_min_pulse();
        test_bounce();
        test_reset_mid_bounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
